// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Used by mem_arbiter and mem_arb_rr.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [2:0] LEN_WORD = 3'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, LSB and downstream memory-controller signals of the memory arbiter.
// master = arbiter side, slave = requesters plus memory controller.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_result;

    logic              d_req;
    logic              d_wr;
    logic [2:0]        d_len;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_value;
    logic              d_ready;
    logic [DATA_W-1:0] d_result;

    logic              m_waiting;
    logic              m_wr;
    logic [2:0]        m_len;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_value;
    logic              m_abort;
    logic              m_ready;
    logic [DATA_W-1:0] m_result;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_len, d_addr, d_value, m_ready, m_result,
        output i_ready, i_result, d_ready, d_result,
        output m_waiting, m_wr, m_len, m_addr, m_value, m_abort
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_len, d_addr, d_value, m_ready, m_result,
        input  i_ready, i_result, d_ready, d_result,
        input  m_waiting, m_wr, m_len, m_addr, m_value, m_abort
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: bit 0 = fetch, bit 1 = LSB.
// On conflict the requester that was not granted last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == OWN_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller between fetch and LSB, one transaction at a time.
// Optional MEM_ARBITER_PERF_EN adds grant/conflict counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [2:0]  I_LEN  = LEN_WORD
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          RoB_clear,
`ifdef MEM_ARBITER_PERF_EN
    output logic [31:0]   perf_i_grants,
    output logic [31:0]   perf_d_grants,
    output logic [31:0]   perf_conflicts,
`endif
    mem_arbiter_if.master bus
);

    state_t     state;
    owner_t     owner;
    owner_t     last_grant;
    logic [1:0] req;
    logic [1:0] grant;
    logic       fetch_live;

    assign req = {bus.d_req, bus.i_req};

    // A fetch whose requester moved on (redirect) must not be reported.
    assign fetch_live = bus.i_req && (bus.i_addr == bus.m_addr);

    mem_arb_rr u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            owner         <= OWN_I;
            last_grant    <= OWN_D;
            bus.m_waiting <= 1'b0;
            bus.m_wr      <= 1'b0;
            bus.m_len     <= '0;
            bus.m_addr    <= '0;
            bus.m_value   <= '0;
            bus.m_abort   <= 1'b0;
            bus.i_ready   <= 1'b0;
            bus.i_result  <= '0;
            bus.d_ready   <= 1'b0;
            bus.d_result  <= '0;
        end else if (rdy_in) begin
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.m_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RoB_clear && (grant != 2'b00)) begin
                        state         <= BUSY;
                        bus.m_waiting <= 1'b1;
                        if (grant[0]) begin
                            owner       <= OWN_I;
                            last_grant  <= OWN_I;
                            bus.m_wr    <= 1'b0;
                            bus.m_len   <= I_LEN;
                            bus.m_addr  <= bus.i_addr;
                            bus.m_value <= '0;
                        end else begin
                            owner       <= OWN_D;
                            last_grant  <= OWN_D;
                            bus.m_wr    <= bus.d_wr;
                            bus.m_len   <= bus.d_len;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_value <= bus.d_value;
                        end
                    end
                end
                BUSY: begin
                    // Committed stores survive a flush; reads are dropped.
                    if (RoB_clear && !bus.m_wr) begin
                        state         <= IDLE;
                        bus.m_waiting <= 1'b0;
                        bus.m_abort   <= 1'b1;
                    end else if (bus.m_ready) begin
                        state         <= IDLE;
                        bus.m_waiting <= 1'b0;
                        if (owner == OWN_I) begin
                            bus.i_result <= bus.m_result;
                            bus.i_ready  <= fetch_live;
                        end else begin
                            bus.d_result <= bus.m_result;
                            bus.d_ready  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else if (rdy_in && (state == IDLE)) begin
            if (req == 2'b11) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
            if (!RoB_clear && grant[0]) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (!RoB_clear && grant[1]) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected downstream requests and responses are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_mem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] value;
    } mreq_t;

    typedef struct packed {
        logic [1:0]  kind;      // 0 = i_ready, 1 = d_ready, 2 = m_abort
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic clear = 1'b0;

    mreq_t req_q[$];
    rsp_t  rsp_q[$];
    int    checks = 0;
    int    errors = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .I_LEN(3'd2)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .RoB_clear      (clear),
`ifdef MEM_ARBITER_PERF_EN
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request or a response.
    logic  prev_wait = 1'b0;
    mreq_t held;
    always @(negedge clk) begin
        mreq_t cur;
        mreq_t e;
        rsp_t  r;
        logic [1:0] kind;
        cur = {bus.m_wr, bus.m_len, bus.m_addr, bus.m_value};
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (bus.m_waiting && !prev_wait) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_m_req", 64'(cur.addr), 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = req_q.pop_front();
                    chk("m_wr", 64'(bus.m_wr), 64'(e.wr));
                    chk("m_len", 64'(bus.m_len), 64'(e.len));
                    chk("m_addr", 64'(bus.m_addr), 64'(e.addr));
                    chk("m_value", 64'(bus.m_value), 64'(e.value));
                end
                held = cur;
            end else if (bus.m_waiting) begin
                chk("m_hold", 64'(cur.addr ^ cur.value ^ {28'b0, cur.wr, cur.len}),
                    64'(held.addr ^ held.value ^ {28'b0, held.wr, held.len}));
            end
            prev_wait = bus.m_waiting;
            if (bus.i_ready || bus.d_ready || bus.m_abort) begin
                kind = bus.m_abort ? 2'd2 : (bus.d_ready ? 2'd1 : 2'd0);
                chk("one_pulse", 64'(32'(bus.i_ready) + 32'(bus.d_ready) + 32'(bus.m_abort)),
                    64'd1);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(kind), 64'd3);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_kind", 64'(kind), 64'(r.kind));
                    if (r.chk_data) begin
                        chk("rsp_data", 64'(kind == 2'd0 ? bus.i_result : bus.d_result),
                            64'(r.data));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_waiting();
        int n = 0;
        while (!bus.m_waiting && n < 20) begin
            tick();
            n++;
        end
        if (!bus.m_waiting) chk("wait_m_waiting_timeout", 64'd0, 64'd1);
    endtask

    // Wait for the downstream request, then complete it after `delay` cycles.
    task automatic serve(input int delay, input logic expect_rsp, input logic [1:0] kind,
                         input logic [31:0] data, input logic chk_data);
        rsp_t r;
        wait_waiting();
        repeat (delay) tick();
        bus.m_ready  = 1'b1;
        bus.m_result = data;
        if (expect_rsp) begin
            r = '{kind: kind, chk_data: chk_data, data: data};
            rsp_q.push_back(r);
        end
        tick();
        bus.m_ready = 1'b0;
    endtask

    function automatic mreq_t ireq(input logic [31:0] a);
        return '{wr: 1'b0, len: 3'd2, addr: a, value: 32'd0};
    endfunction

    function automatic rsp_t abort_rsp();
        return '{kind: 2'd2, chk_data: 1'b0, data: 32'd0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_wr = 0; bus.d_len = 0;
        bus.d_addr = 0; bus.d_value = 0; bus.m_ready = 0; bus.m_result = 0;
        repeat (3) tick();
        chk("rst_m_waiting", 64'(bus.m_waiting), 64'd0);
        chk("rst_i_ready", 64'(bus.i_ready), 64'd0);
        chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
        chk("rst_m_abort", 64'(bus.m_abort), 64'd0);
        chk("rst_m_addr", 64'(bus.m_addr), 64'd0);
        chk("rst_i_result", 64'(bus.i_result), 64'd0);
        rst = 1'b0;
        tick();

        // Conflicts alternate I, D, I; last_grant starts at D.
        req_q.push_back(ireq(32'h1100));
        req_q.push_back('{wr: 1'b0, len: 3'd2, addr: 32'h2000, value: 32'd0});
        req_q.push_back(ireq(32'h1104));
        req_q.push_back('{wr: 1'b0, len: 3'd1, addr: 32'h2004, value: 32'd0});
        bus.i_req = 1; bus.i_addr = 32'h1100;
        bus.d_req = 1; bus.d_wr = 0; bus.d_len = 3'd2; bus.d_addr = 32'h2000;
        serve(1, 1'b1, 2'd0, 32'hA0A0_0001, 1'b1);
        bus.i_addr = 32'h1104;
        serve(2, 1'b1, 2'd1, 32'hB0B0_0002, 1'b1);
        bus.d_len = 3'd1; bus.d_addr = 32'h2004;
        serve(1, 1'b1, 2'd0, 32'hA0A0_0003, 1'b1);
        bus.i_req = 0;
        serve(0, 1'b1, 2'd1, 32'hB0B0_0004, 1'b1);
        bus.d_req = 0;
        tick();

        // Single fetch, completion 5 cycles after m_waiting, i_ready the cycle after.
        req_q.push_back(ireq(32'h1000));
        bus.i_req = 1; bus.i_addr = 32'h1000;
        serve(5, 1'b1, 2'd0, 32'hDEAD_BEEF, 1'b1);
        chk("fetch_ready_latency", 64'(bus.i_ready), 64'd1);
        bus.i_req = 0;
        tick();
        chk("fetch_ready_pulse", 64'(bus.i_ready), 64'd0);

        // Redirect while BUSY: stale data suppressed, new address fetched next.
        req_q.push_back(ireq(32'h1000));
        bus.i_req = 1; bus.i_addr = 32'h1000;
        wait_waiting();
        tick(); tick();
        bus.i_addr = 32'h1040;
        req_q.push_back(ireq(32'h1040));
        serve(1, 1'b0, 2'd0, 32'h5757_5757, 1'b0);
        chk("redirect_suppressed", 64'(bus.i_ready), 64'd0);
        serve(1, 1'b1, 2'd0, 32'h1040_1040, 1'b1);
        bus.i_req = 0;
        tick();

        // Load flushed while BUSY.
        req_q.push_back('{wr: 1'b0, len: 3'd2, addr: 32'h2000, value: 32'd0});
        bus.d_req = 1; bus.d_wr = 0; bus.d_len = 3'd2; bus.d_addr = 32'h2000;
        wait_waiting();
        tick(); tick();
        clear = 1; bus.d_req = 0;
        rsp_q.push_back(abort_rsp());
        tick();
        clear = 0;
        chk("load_clear_m_waiting", 64'(bus.m_waiting), 64'd0);
        chk("load_clear_abort", 64'(bus.m_abort), 64'd1);
        tick();
        chk("load_clear_abort_pulse", 64'(bus.m_abort), 64'd0);

        // Load flush coincident with m_ready: flush wins.
        req_q.push_back('{wr: 1'b0, len: 3'd0, addr: 32'h2100, value: 32'd0});
        bus.d_req = 1; bus.d_len = 3'd0; bus.d_addr = 32'h2100;
        wait_waiting();
        tick();
        clear = 1; bus.d_req = 0; bus.m_ready = 1; bus.m_result = 32'h1234_5678;
        rsp_q.push_back(abort_rsp());
        tick();
        clear = 0; bus.m_ready = 0;
        chk("load_clear_rdy_no_dready", 64'(bus.d_ready), 64'd0);
        tick();

        // Store flushed while BUSY keeps going.
        req_q.push_back('{wr: 1'b1, len: 3'd1, addr: 32'h3000, value: 32'h0000_55AA});
        bus.d_req = 1; bus.d_wr = 1; bus.d_len = 3'd1; bus.d_addr = 32'h3000;
        bus.d_value = 32'h0000_55AA;
        wait_waiting();
        clear = 1;
        tick();
        clear = 0;
        chk("store_clear_held", 64'(bus.m_waiting), 64'd1);
        serve(2, 1'b1, 2'd1, 32'd0, 1'b0);
        chk("store_done", 64'(bus.d_ready), 64'd1);
        bus.d_req = 0;
        tick();

        // Store flush coincident with m_ready: store still reported.
        req_q.push_back('{wr: 1'b1, len: 3'd2, addr: 32'h3100, value: 32'hCAFE_F00D});
        bus.d_req = 1; bus.d_wr = 1; bus.d_len = 3'd2; bus.d_addr = 32'h3100;
        bus.d_value = 32'hCAFE_F00D;
        wait_waiting();
        clear = 1; bus.m_ready = 1;
        rsp_q.push_back('{kind: 2'd1, chk_data: 1'b0, data: 32'd0});
        tick();
        clear = 0; bus.m_ready = 0; bus.d_req = 0; bus.d_wr = 0;
        tick();

        // Stall with m_ready high: nothing completes until rdy returns.
        req_q.push_back(ireq(32'h1200));
        bus.i_req = 1; bus.i_addr = 32'h1200;
        wait_waiting();
        rdy = 0; bus.m_ready = 1; bus.m_result = 32'h7777_1200;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_no_ready", 64'(bus.i_ready), 64'd0);
            chk("stall_waiting", 64'(bus.m_waiting), 64'd1);
        end
        rsp_q.push_back('{kind: 2'd0, chk_data: 1'b1, data: 32'h7777_1200});
        rdy = 1;
        tick();
        bus.m_ready = 0; bus.i_req = 0;
        chk("stall_release_ready", 64'(bus.i_ready), 64'd1);
        tick();

        // Flush in IDLE blocks the grant for that cycle.
        bus.i_req = 1; bus.i_addr = 32'h1300; clear = 1;
        tick();
        clear = 0;
        chk("idle_clear_no_grant", 64'(bus.m_waiting), 64'd0);
        req_q.push_back(ireq(32'h1300));
        serve(0, 1'b1, 2'd0, 32'h1300_0013, 1'b1);
        bus.i_req = 0;
        repeat (3) tick();

        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
`ifdef MEM_ARBITER_PERF_EN
        chk("perf_i_grants", 64'(perf_i_grants), 64'd7);
        chk("perf_d_grants", 64'(perf_d_grants), 64'd6);
        chk("perf_conflicts", 64'(perf_conflicts), 64'd3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
